// File: rtl/hough_peak_if.sv
// Bus between the Hough peak selector and its environment: scan control,
// accumulator BRAM read port, selected-line results and a state probe.
interface hough_peak_if #(
  parameter int THETA_UNROLL     = 4,
  parameter int ACCUM_BUFF_WIDTH = 16,
  parameter int THETA_BITS       = 8,
  parameter int ADDR_BITS        = 18
);
  // Handshake: start is a one-cycle request honoured only while busy is low and
  // no result is being published; peak_done is a one-cycle completion strobe and
  // the result fields are stable from that cycle until the next peak_done.
  logic                                             start;
  logic [ADDR_BITS-1:0]                             accum_rd_addr;
  logic [0:THETA_UNROLL-1][ACCUM_BUFF_WIDTH-1:0]    accum_rd_data;
  logic                                             busy;
  logic                                             peak_done;
  logic signed [15:0]                               left_rho_out;
  logic signed [15:0]                               right_rho_out;
  logic [THETA_BITS-1:0]                            left_theta_out;
  logic [THETA_BITS-1:0]                            right_theta_out;
  logic                                             left_valid;
  logic                                             right_valid;
  logic [1:0]                                       dbg_state;

  modport master (
    output start, accum_rd_data,
    input  accum_rd_addr, busy, peak_done, left_rho_out, right_rho_out,
           left_theta_out, right_theta_out, left_valid, right_valid, dbg_state
  );

  modport slave (
    input  start, accum_rd_data,
    output accum_rd_addr, busy, peak_done, left_rho_out, right_rho_out,
           left_theta_out, right_theta_out, left_valid, right_valid, dbg_state
  );
endinterface

// File: rtl/hough_peak_select.sv
// Single pass over the Hough accumulator BRAM picking the strongest left-lane and
// right-lane cell. Optional macro HOUGH_PEAK_THRESHOLD_EN enforces MIN_VOTES.
module hough_peak_select #(
  parameter int THETAS           = 180,
  parameter int THETA_UNROLL     = 4,
  parameter int RHOS             = 1469,
  parameter int RHO_RANGE        = 2939,
  parameter int ACCUM_BUFF_WIDTH = 16,
  parameter int THETA_BITS       = 8,
  parameter int LEFT_THETA_MIN   = 100,
  parameter int LEFT_THETA_MAX   = 170,
  parameter int RIGHT_THETA_MIN  = 10,
  parameter int RIGHT_THETA_MAX  = 80,
  parameter int MIN_VOTES        = 20,
  parameter int ADDR_BITS        = $clog2(RHO_RANGE * THETAS / THETA_UNROLL)
) (
  input logic         clock,
  input logic         reset,
  hough_peak_if.slave bus
);

  localparam int WORDS     = THETAS / THETA_UNROLL;
  localparam int N_WORDS   = RHO_RANGE * WORDS;
  localparam int RHO_BITS  = $clog2(RHO_RANGE + 1);
  localparam int WORD_BITS = $clog2(WORDS + 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N_WORDS - 1);
  // A mis-parameterised instance never leaves IDLE.
  localparam bit PARAMS_OK = (THETAS % THETA_UNROLL == 0) && (MIN_VOTES >= 0) && (RHO_RANGE > 0);

`ifdef HOUGH_PEAK_THRESHOLD_EN
  localparam logic [ACCUM_BUFF_WIDTH-1:0] VOTE_FLOOR = ACCUM_BUFF_WIDTH'(MIN_VOTES);
`else
  localparam logic [ACCUM_BUFF_WIDTH-1:0] VOTE_FLOOR = ACCUM_BUFF_WIDTH'(1);
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  typedef struct packed {
    logic                        found;
    logic [ACCUM_BUFF_WIDTH-1:0] val;
    logic [THETA_BITS-1:0]       theta;
  } cand_t;

  state_t                      state;
  logic [ADDR_BITS-1:0]        addr_q;
  logic [RHO_BITS-1:0]         rho_cnt;
  logic [WORD_BITS-1:0]        word_cnt;
  logic                        d_valid;
  logic [RHO_BITS-1:0]         d_rho;
  logic [WORD_BITS-1:0]        d_word;

  logic [ACCUM_BUFF_WIDTH-1:0] left_best_val, right_best_val;
  logic [RHO_BITS-1:0]         left_best_rho, right_best_rho;
  logic [THETA_BITS-1:0]       left_best_theta, right_best_theta;

  logic                        busy_q, done_q;
  logic                        left_valid_q, right_valid_q;
  logic [15:0]                 left_rho_q, right_rho_q;
  logic [THETA_BITS-1:0]       left_theta_q, right_theta_q;

  cand_t                       left_cand, right_cand;
  logic                        left_take, right_take;
  logic [ACCUM_BUFF_WIDTH-1:0] left_val_nx, right_val_nx;
  logic [RHO_BITS-1:0]         left_rho_nx, right_rho_nx;
  logic [THETA_BITS-1:0]       left_theta_nx, right_theta_nx;
  logic                        left_ok, right_ok;
  logic [15:0]                 left_rho_res, right_rho_res;
  int                          base_theta;

  // Strict '>' while walking lanes upward keeps the lowest lane on equal counts.
  function automatic cand_t pick(input logic [0:THETA_UNROLL-1][ACCUM_BUFF_WIDTH-1:0] word_data,
                                 input int base, input int lo, input int hi);
    cand_t c;
    int    th;
    c = '0;
    for (int l = 0; l < THETA_UNROLL; l++) begin
      th = base + l;
      if (th >= lo && th <= hi && (!c.found || word_data[l] > c.val)) begin
        c.found = 1'b1;
        c.val   = word_data[l];
        c.theta = THETA_BITS'(th);
      end
    end
    return c;
  endfunction

  always_comb begin
    base_theta = int'(d_word) * THETA_UNROLL;
    left_cand  = pick(bus.accum_rd_data, base_theta, LEFT_THETA_MIN, LEFT_THETA_MAX);
    right_cand = pick(bus.accum_rd_data, base_theta, RIGHT_THETA_MIN, RIGHT_THETA_MAX);

    left_take  = d_valid && left_cand.found && (left_cand.val > left_best_val);
    right_take = d_valid && right_cand.found && (right_cand.val > right_best_val);

    left_val_nx    = left_take ? left_cand.val   : left_best_val;
    left_rho_nx    = left_take ? d_rho           : left_best_rho;
    left_theta_nx  = left_take ? left_cand.theta : left_best_theta;
    right_val_nx   = right_take ? right_cand.val   : right_best_val;
    right_rho_nx   = right_take ? d_rho            : right_best_rho;
    right_theta_nx = right_take ? right_cand.theta : right_best_theta;

    left_ok       = (left_val_nx >= VOTE_FLOOR);
    right_ok      = (right_val_nx >= VOTE_FLOOR);
    left_rho_res  = left_ok  ? 16'(left_rho_nx)  - 16'(RHOS) : '0;
    right_rho_res = right_ok ? 16'(right_rho_nx) - 16'(RHOS) : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      addr_q           <= '0;
      rho_cnt          <= '0;
      word_cnt         <= '0;
      d_valid          <= 1'b0;
      d_rho            <= '0;
      d_word           <= '0;
      left_best_val    <= '0;
      left_best_rho    <= '0;
      left_best_theta  <= '0;
      right_best_val   <= '0;
      right_best_rho   <= '0;
      right_best_theta <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      left_valid_q     <= 1'b0;
      right_valid_q    <= 1'b0;
      left_rho_q       <= '0;
      right_rho_q      <= '0;
      left_theta_q     <= '0;
      right_theta_q    <= '0;
    end else begin
      done_q           <= 1'b0;
      // Tag travels with the address now on the bus; its data returns next cycle.
      d_valid          <= (state == SCAN);
      d_rho            <= rho_cnt;
      d_word           <= word_cnt;
      left_best_val    <= left_val_nx;
      left_best_rho    <= left_rho_nx;
      left_best_theta  <= left_theta_nx;
      right_best_val   <= right_val_nx;
      right_best_rho   <= right_rho_nx;
      right_best_theta <= right_theta_nx;

      case (state)
        IDLE: begin
          if (bus.start && PARAMS_OK) begin
            state            <= SCAN;
            busy_q           <= 1'b1;
            addr_q           <= '0;
            rho_cnt          <= '0;
            word_cnt         <= '0;
            left_best_val    <= '0;
            left_best_rho    <= '0;
            left_best_theta  <= '0;
            right_best_val   <= '0;
            right_best_rho   <= '0;
            right_best_theta <= '0;
          end
        end
        SCAN: begin
          if (addr_q == LAST_ADDR) begin
            state <= DRAIN;
          end else begin
            addr_q <= addr_q + ADDR_BITS'(1);
            if (word_cnt == WORD_BITS'(WORDS - 1)) begin
              word_cnt <= '0;
              rho_cnt  <= rho_cnt + RHO_BITS'(1);
            end else begin
              word_cnt <= word_cnt + WORD_BITS'(1);
            end
          end
        end
        DRAIN: begin
          // Publish using bests that already include the final word.
          state         <= DONE;
          busy_q        <= 1'b0;
          done_q        <= 1'b1;
          left_valid_q  <= left_ok;
          left_rho_q    <= left_rho_res;
          left_theta_q  <= left_ok ? left_theta_nx : '0;
          right_valid_q <= right_ok;
          right_rho_q   <= right_rho_res;
          right_theta_q <= right_ok ? right_theta_nx : '0;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.accum_rd_addr   = addr_q;
  assign bus.busy            = busy_q;
  assign bus.peak_done       = done_q;
  assign bus.left_valid      = left_valid_q;
  assign bus.right_valid     = right_valid_q;
  assign bus.left_rho_out    = left_rho_q;
  assign bus.right_rho_out   = right_rho_q;
  assign bus.left_theta_out  = left_theta_q;
  assign bus.right_theta_out = right_theta_q;
  assign bus.dbg_state       = state;

endmodule

// File: tb/tb_hough_peak_select.sv
// Directed bench for hough_peak_select on a reduced buffer (800 rho x 180 theta,
// 20 thetas per word) so that every scan is 7200 cycles.
module tb_hough_peak_select;

  localparam int THETAS    = 180;
  localparam int U         = 20;
  localparam int RHOS      = 200;
  localparam int RHO_RANGE = 800;
  localparam int WORDS     = THETAS / U;
  localparam int N         = RHO_RANGE * WORDS;
  localparam int AB        = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  int unsigned     cells[int];
  logic [AB-1:0]   exp_q[$];

  hough_peak_if #(.THETA_UNROLL(U), .ACCUM_BUFF_WIDTH(16), .THETA_BITS(8), .ADDR_BITS(AB)) bus ();

  hough_peak_select #(
    .THETAS(THETAS), .THETA_UNROLL(U), .RHOS(RHOS), .RHO_RANGE(RHO_RANGE),
    .ACCUM_BUFF_WIDTH(16), .THETA_BITS(8),
    .LEFT_THETA_MIN(100), .LEFT_THETA_MAX(170),
    .RIGHT_THETA_MIN(10), .RIGHT_THETA_MAX(80),
    .MIN_VOTES(20), .ADDR_BITS(AB)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- BRAM model: one-cycle read latency ----------------
  function automatic int unsigned cell_at(input int rho, input int theta);
    int k;
    k = rho * THETAS + theta;
    return cells.exists(k) ? cells[k] : 0;
  endfunction

  always @(posedge clk) begin : bram_model
    int a;
    a = int'(bus.accum_rd_addr);
    for (int l = 0; l < U; l++) begin
      bus.accum_rd_data[l] <= 16'(cell_at(a / WORDS, (a % WORDS) * U + l));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input int rho, input int theta, input int unsigned val);
    cells[rho * THETAS + theta] = val;
  endtask

  function automatic logic [49:0] outs();
    return {bus.left_valid, bus.left_rho_out, bus.left_theta_out,
            bus.right_valid, bus.right_rho_out, bus.right_theta_out};
  endfunction

  // Runs one scan and checks address sequence, busy, held outputs and done timing.
  task automatic do_scan(input string name, input bit busy_pulses, input bit launch, input bit chain_next);
    logic [49:0]   held;
    logic [AB-1:0] exp_a;
    logic [AB-1:0] bad_addr;
    int            done_cnt, done_at, addr_bad_j, hold_bad_j, busy_bad_j;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(AB'(i));
    if (launch) begin
      @(negedge clk);
      bus.start = 1'b1;
    end
    held = outs();
    done_cnt = 0; done_at = -1; addr_bad_j = -1; hold_bad_j = -1; busy_bad_j = -1;
    bad_addr = '0;
    for (int j = 1; j <= N + 3; j++) begin
      @(negedge clk);
      if (j <= N) begin
        exp_a = exp_q.pop_front();
        if (bus.accum_rd_addr !== exp_a && addr_bad_j < 0) begin
          addr_bad_j = j;
          bad_addr   = bus.accum_rd_addr;
        end
      end
      if ((bus.busy !== (j <= N + 1)) && busy_bad_j < 0) busy_bad_j = j;
      if (bus.peak_done === 1'b1) begin
        done_cnt++;
        done_at = j;
      end
      if (j < N + 2 && outs() !== held && hold_bad_j < 0) hold_bad_j = j;
      bus.start = (busy_pulses && (j == 5 || j == N + 1 || j == N + 2)) || (chain_next && j == N + 3);
    end
    total++;
    if (addr_bad_j >= 0) begin
      bad++;
      $display("FAIL %s addr_seq: cycle E+%0d got addr %0d want %0d", name, addr_bad_j, bad_addr, addr_bad_j - 1);
    end
    total++;
    if (busy_bad_j >= 0) begin
      bad++;
      $display("FAIL %s busy: wrong busy level first at cycle E+%0d", name, busy_bad_j);
    end
    total++;
    if (done_cnt != 1 || done_at != N + 2) begin
      bad++;
      $display("FAIL %s peak_done: got %0d pulses last at E+%0d want 1 pulse at E+%0d", name, done_cnt, done_at, N + 2);
    end
    total++;
    if (hold_bad_j >= 0) begin
      bad++;
      $display("FAIL %s output_hold: outputs changed mid-scan at cycle E+%0d", name, hold_bad_j);
    end
    total++;
    if (bus.accum_rd_addr !== AB'(N - 1) || bus.dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL %s idle_after: got addr=%0d state=%0d want addr=%0d state=0", name, bus.accum_rd_addr, bus.dbg_state, N - 1);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (outs() !== 50'd0) begin
      bad++;
      $display("FAIL reset outputs: got %h want 0", outs());
    end
    total++;
    if ({bus.busy, bus.peak_done, bus.dbg_state, bus.accum_rd_addr} !== '0) begin
      bad++;
      $display("FAIL reset control: got busy=%0b done=%0b state=%0d addr=%0d want all 0",
               bus.busy, bus.peak_done, bus.dbg_state, bus.accum_rd_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_two_peak();
    cells.delete();
    put(RHOS + 575, 60, 50);
    put(RHOS - 163, 128, 40);
    do_scan("two_peak", 1'b1, 1'b1, 1'b0);
    total++;
    if ({bus.right_valid, bus.right_rho_out, bus.right_theta_out} !== {1'b1, 16'sd575, 8'd60}) begin
      bad++;
      $display("FAIL two_peak right: got v=%0b rho=%0d th=%0d want v=1 rho=575 th=60",
               bus.right_valid, bus.right_rho_out, bus.right_theta_out);
    end
    total++;
    if ({bus.left_valid, bus.left_rho_out, bus.left_theta_out} !== {1'b1, -16'sd163, 8'd128}) begin
      bad++;
      $display("FAIL two_peak left: got v=%0b rho=%0d th=%0d want v=1 rho=-163 th=128",
               bus.left_valid, bus.left_rho_out, bus.left_theta_out);
    end
  endtask

  task automatic test_tie_rho();
    cells.delete();
    put(10, 60, 30);
    put(20, 60, 30);
    do_scan("tie_rho", 1'b0, 1'b1, 1'b0);
    total++;
    if ({bus.right_valid, bus.right_rho_out, bus.right_theta_out} !== {1'b1, -16'sd190, 8'd60}) begin
      bad++;
      $display("FAIL tie_rho right: got v=%0b rho=%0d th=%0d want v=1 rho=-190 th=60",
               bus.right_valid, bus.right_rho_out, bus.right_theta_out);
    end
    total++;
    if ({bus.left_valid, bus.left_rho_out, bus.left_theta_out} !== {1'b0, 16'sd0, 8'd0}) begin
      bad++;
      $display("FAIL tie_rho left_empty: got v=%0b rho=%0d th=%0d want v=0 rho=0 th=0",
               bus.left_valid, bus.left_rho_out, bus.left_theta_out);
    end
  endtask

  task automatic test_tie_theta();
    cells.delete();
    put(300, 61, 45);
    put(300, 62, 45);
    do_scan("tie_theta", 1'b0, 1'b1, 1'b0);
    total++;
    if ({bus.right_valid, bus.right_rho_out, bus.right_theta_out} !== {1'b1, 16'sd100, 8'd61}) begin
      bad++;
      $display("FAIL tie_theta right: got v=%0b rho=%0d th=%0d want v=1 rho=100 th=61",
               bus.right_valid, bus.right_rho_out, bus.right_theta_out);
    end
  endtask

  task automatic test_out_of_window();
    cells.delete();
    put(400, 90, 900);
    put(50, 40, 25);
    do_scan("out_of_window", 1'b0, 1'b1, 1'b0);
    total++;
    if ({bus.right_valid, bus.right_rho_out, bus.right_theta_out} !== {1'b1, -16'sd150, 8'd40}) begin
      bad++;
      $display("FAIL out_of_window right: got v=%0b rho=%0d th=%0d want v=1 rho=-150 th=40",
               bus.right_valid, bus.right_rho_out, bus.right_theta_out);
    end
    total++;
    if ({bus.left_valid, bus.left_rho_out, bus.left_theta_out} !== {1'b0, 16'sd0, 8'd0}) begin
      bad++;
      $display("FAIL out_of_window left: got v=%0b rho=%0d th=%0d want v=0 rho=0 th=0",
               bus.left_valid, bus.left_rho_out, bus.left_theta_out);
    end
  endtask

  task automatic test_threshold();
    logic [24:0] exp_left;
`ifdef HOUGH_PEAK_THRESHOLD_EN
    exp_left = {1'b0, 16'sd0, 8'd0};
`else
    exp_left = {1'b1, 16'sd300, 8'd150};
`endif
    cells.delete();
    put(500, 150, 19);
    put(210, 20, 20);
    do_scan("threshold", 1'b0, 1'b1, 1'b0);
    total++;
    if ({bus.left_valid, bus.left_rho_out, bus.left_theta_out} !== exp_left) begin
      bad++;
      $display("FAIL threshold left: got v=%0b rho=%0d th=%0d want v=%0b rho=%0d th=%0d",
               bus.left_valid, bus.left_rho_out, bus.left_theta_out,
               exp_left[24], $signed(exp_left[23:8]), exp_left[7:0]);
    end
    total++;
    if ({bus.right_valid, bus.right_rho_out, bus.right_theta_out} !== {1'b1, 16'sd10, 8'd20}) begin
      bad++;
      $display("FAIL threshold right: got v=%0b rho=%0d th=%0d want v=1 rho=10 th=20",
               bus.right_valid, bus.right_rho_out, bus.right_theta_out);
    end
  endtask

  task automatic test_reset_mid_scan();
    cells.delete();
    put(RHOS + 575, 60, 50);
    put(RHOS - 163, 128, 40);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (outs() !== 50'd0) begin
      bad++;
      $display("FAIL reset_mid_scan outputs: got %h want 0", outs());
    end
    total++;
    if ({bus.busy, bus.peak_done, bus.dbg_state, bus.accum_rd_addr} !== '0) begin
      bad++;
      $display("FAIL reset_mid_scan control: got busy=%0b done=%0b state=%0d addr=%0d want all 0",
               bus.busy, bus.peak_done, bus.dbg_state, bus.accum_rd_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    do_scan("rescan", 1'b0, 1'b1, 1'b0);
    total++;
    if (outs() !== {1'b1, -16'sd163, 8'd128, 1'b1, 16'sd575, 8'd60}) begin
      bad++;
      $display("FAIL rescan results: got L v=%0b rho=%0d th=%0d R v=%0b rho=%0d th=%0d want L 1/-163/128 R 1/575/60",
               bus.left_valid, bus.left_rho_out, bus.left_theta_out,
               bus.right_valid, bus.right_rho_out, bus.right_theta_out);
    end
  endtask

  task automatic test_back_to_back();
    cells.delete();
    put(0, 100, 77);
    put(799, 80, 66);
    put(5, 99, 500);
    put(6, 171, 500);
    put(7, 9, 500);
    put(8, 81, 500);
    do_scan("b2b_first", 1'b0, 1'b1, 1'b1);
    total++;
    if (outs() !== {1'b1, -16'sd200, 8'd100, 1'b1, 16'sd599, 8'd80}) begin
      bad++;
      $display("FAIL b2b_first results: got L v=%0b rho=%0d th=%0d R v=%0b rho=%0d th=%0d want L 1/-200/100 R 1/599/80",
               bus.left_valid, bus.left_rho_out, bus.left_theta_out,
               bus.right_valid, bus.right_rho_out, bus.right_theta_out);
    end
    cells.delete();
    do_scan("b2b_second", 1'b0, 1'b0, 1'b0);
    total++;
    if (outs() !== 50'd0) begin
      bad++;
      $display("FAIL b2b_second all_zero: got %h want 0", outs());
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_two_peak();
    test_tie_rho();
    test_tie_theta();
    test_out_of_window();
    test_threshold();
    test_reset_mid_scan();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
